// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: owns the PC, fetches words over imem req/ack, hands them to IF/ID and applies beq/j/jr redirects.
// Optional misaligned-target fault (adel_err, FAULT state) is built when IFETCH_ALIGN_CHECK_EN is defined.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redir_valid,
    input  logic [2:0]  redir_op,
    input  logic        redir_zero,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        redir_taken,
    output logic        adel_err
);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {BOOT, REQ, HOLD, DRAIN, FAULT} state_t;
`else
    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        boot_arm_q;
    logic [31:0] br_offset;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign redir_taken = redir_valid & ((redir_op == 3'b010) | (redir_op == 3'b011) |
                                        ((redir_op == 3'b001) & redir_zero));

    always_comb begin
        br_offset = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
        case (redir_op)
            3'b001:  raw_target = redir_pc + 32'd4 + br_offset;
            3'b010:  raw_target = {redir_pc[31:28], redir_imm, 2'b00};
            3'b011:  raw_target = redir_reg;
            default: raw_target = redir_pc + 32'd4;
        endcase
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic adel_q, adel_d;
    logic misaligned;
    assign target     = raw_target;
    assign misaligned = redir_taken & (raw_target[1:0] != 2'b00);
    assign adel_err   = adel_q;
`else
    assign target     = raw_target & 32'hFFFF_FFFC;
    assign adel_err   = 1'b0;
`endif

    assign imem_req  = (state_q == REQ) | (state_q == DRAIN);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == HOLD);
    assign if_instr  = instr_q;
    assign if_pc     = ipc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        adel_d  = adel_q | misaligned;
`endif
        case (state_q)
            BOOT: begin
                if (redir_taken) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (boot_arm_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redir_taken) begin
                        pc_d = target;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        state_d = HOLD;
                    end
                end else if (redir_taken) begin
                    tgt_d   = target;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redir_taken) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A redirect arriving with the stale ack beats the one already saved in tgt_q.
                if (redir_taken) begin
                    tgt_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redir_taken ? target : tgt_q;
                    state_d = REQ;
                end
            end
            default: ;
        endcase
`ifdef IFETCH_ALIGN_CHECK_EN
        if ((state_q != FAULT) && adel_d &&
            ((state_q == BOOT) || (state_q == HOLD) || imem_ack)) begin
            state_d = FAULT;
        end
`endif
    end

    // The first edge after rst_n rises only arms BOOT, so the first request appears on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            instr_q    <= 32'd0;
            ipc_q      <= RESET_PC;
            boot_arm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            boot_arm_q <= 1'b1;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed fetch/redirect scenarios plus a randomized run against a transaction-level model.
// Build with IFETCH_ALIGN_CHECK_EN defined to exercise the misaligned-target fault.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [2:0]  redir_op = 3'd0;
    logic        redir_zero = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic [25:0] redir_imm = 26'd0;
    logic [31:0] redir_reg = 32'd0;
    logic        redir_taken;
    logic        adel_err;

    int checks = 0;
    int failures = 0;

    // Instruction memory: per-request latency, optional stray ack pulse.
    bit  mem_busy = 1'b0;
    int  mem_cnt = 0;
    int  mem_lat = 0;
    bit  stale_ack = 1'b0;
    bit  last_taken = 1'b0;

    // Reference model: what the fetcher has outstanding and what it is presenting.
    int          m_boot_left;
    bit          m_busy, m_stale, m_valid, m_adel, m_fault, m_fault_pend;
    logic [31:0] m_pc, m_tgt, m_instr, m_ipc;

    ifetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_zero  (redir_zero),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_reg   (redir_reg),
        .redir_taken (redir_taken),
        .adel_err    (adel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_boot_left  = 2;
        m_busy       = 1'b0;
        m_stale      = 1'b0;
        m_valid      = 1'b0;
        m_adel       = 1'b0;
        m_fault      = 1'b0;
        m_fault_pend = 1'b0;
        m_pc         = 32'h0000_3000;
        m_tgt        = 32'h0000_3000;
        m_instr      = 32'd0;
        m_ipc        = 32'h0000_3000;
    endtask

    // One clock of the model given this cycle's ack, redirect decision and if_ready.
    task automatic modelStep(input bit ack, input bit tk, input bit mis,
                             input logic [31:0] t, input bit rdy);
        if (m_fault) begin
        end else if (m_boot_left > 0) begin
            if (tk) begin
                m_boot_left = 0;
                if (mis) begin m_adel = 1; m_fault = 1; end
                else begin m_pc = t; m_busy = 1; end
            end else begin
                m_boot_left--;
                if (m_boot_left == 0) m_busy = 1;
            end
        end else if (m_busy && !m_stale) begin
            if (ack) begin
                if (tk) begin
                    if (mis) begin m_adel = 1; m_fault = 1; m_busy = 0; end
                    else m_pc = t;
                end else begin
                    m_valid = 1; m_instr = wordOf(m_pc); m_ipc = m_pc; m_busy = 0;
                end
            end else if (tk) begin
                m_stale = 1; m_tgt = t;
                if (mis) begin m_adel = 1; m_fault_pend = 1; end
            end
        end else if (m_busy && m_stale) begin
            if (tk) begin
                m_tgt = t;
                if (mis) begin m_adel = 1; m_fault_pend = 1; end
            end
            if (ack) begin
                m_stale = 0;
                if (m_fault_pend) begin m_fault = 1; m_busy = 0; end
                else m_pc = m_tgt;
            end
        end else if (m_valid) begin
            if (tk) begin
                m_valid = 0;
                if (mis) begin m_adel = 1; m_fault = 1; end
                else begin m_pc = t; m_busy = 1; end
            end else if (rdy) begin
                m_valid = 0; m_busy = 1; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Drive one cycle (called at posedge+1), advance the model, then compare after the next edge.
    task automatic applyStimulus(input logic rv, input logic [2:0] op, input logic zero,
                                 input logic [31:0] rpc, input logic [25:0] imm,
                                 input logic [31:0] rreg, input logic rdy);
        bit              tk, mis;
        logic [31:0]     t;
        logic signed [15:0] s16;
        int              off;
        if (imem_req === 1'b1 && !mem_busy) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
        end
        imem_ack    = stale_ack || (mem_busy && mem_cnt == 0);
        stale_ack   = 1'b0;
        imem_rdata  = imem_ack ? wordOf(imem_addr) : $urandom;
        redir_valid = rv;
        redir_op    = op;
        redir_zero  = zero;
        redir_pc    = rpc;
        redir_imm   = imm;
        redir_reg   = rreg;
        if_ready    = rdy;

        tk  = rv && (op == 3'b010 || op == 3'b011 || (op == 3'b001 && zero));
        s16 = imm[15:0];
        off = int'(s16) * 4;
        case (op)
            3'b001:  t = rpc + 32'd4 + 32'(off);
            3'b010:  t = (rpc & 32'hF000_0000) | ({6'b0, imm} << 2);
            3'b011:  t = rreg;
            default: t = rpc + 32'd4;
        endcase
`ifdef IFETCH_ALIGN_CHECK_EN
        mis = tk && ((t % 4) != 0);
`else
        t   = t - (t % 4);
        mis = 1'b0;
`endif
        #1;
        last_taken = redir_taken;
        checkOutput("redir_taken", {31'b0, redir_taken}, {31'b0, tk});
        modelStep(imem_ack, tk, mis, t, rdy);
        if (imem_ack) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;

        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        if (m_busy) checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        checkOutput("if_instr", if_instr, m_instr);
        checkOutput("if_pc", if_pc, m_ipc);
        checkOutput("adel_err", {31'b0, adel_err}, {31'b0, m_adel});
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 3'b000, 1'b0, 32'd0, 26'd0, 32'd0, rdy);
    endtask

    // Asserts rst_n from posedge+1 (possibly mid-request), checks reset values, releases at posedge+1.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        imem_ack    = 1'b0;
        redir_valid = 1'b0;
        if_ready    = 1'b0;
        mem_busy    = 1'b0;
        stale_ack   = 1'b0;
        modelReset();
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0000_3000);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'h0000_3000);
        checkOutput("rst_adel_err", {31'b0, adel_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rreg;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        // Zero-wait sequential fetch: 0x3000, 0x3004 then a 5-cycle stall at 0x3004.
        mem_lat = 0;
        idle(1'b1);
        checkOutput("boot_no_req", {31'b0, imem_req}, 32'd0);
        idle(1'b1);
        checkOutput("first_req", {31'b0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0000_3000);
        idle(1'b1);
        checkOutput("first_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("first_if_pc", if_pc, 32'h0000_3000);
        idle(1'b1);
        checkOutput("second_addr", imem_addr, 32'h0000_3004);
        checkOutput("valid_pulse_low", {31'b0, if_valid}, 32'd0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            checkOutput("stall_if_pc", if_pc, 32'h0000_3004);
            checkOutput("stall_if_instr", if_instr, wordOf(32'h0000_3004));
            checkOutput("stall_no_req", {31'b0, imem_req}, 32'd0);
        end
        idle(1'b1);
        checkOutput("after_stall_addr", imem_addr, 32'h0000_3008);
        idle(1'b1);

        // beq taken back to 0x3004, then not taken (sequential).
        applyStimulus(1'b1, 3'b001, 1'b1, 32'h0000_3010, 26'h000_FFFC, 32'd0, 1'b1);
        checkOutput("beq_taken", {31'b0, last_taken}, 32'd1);
        checkOutput("beq_target", imem_addr, 32'h0000_3004);
        idle(1'b1);
        applyStimulus(1'b1, 3'b001, 1'b0, 32'h0000_3010, 26'h000_FFFC, 32'd0, 1'b1);
        checkOutput("beq_not_taken", {31'b0, last_taken}, 32'd0);
        checkOutput("beq_nt_addr", imem_addr, 32'h0000_3008);
        idle(1'b1);

        // jal while the request waits on a late ack: stale data must be dropped.
        mem_lat = 3;
        idle(1'b1);
        applyStimulus(1'b1, 3'b010, 1'b0, 32'h0000_3008, 26'h000_0C10, 32'd0, 1'b1);
        checkOutput("drain_old_addr", imem_addr, 32'h0000_300C);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("drain_no_valid", {31'b0, if_valid}, 32'd0);
        end
        checkOutput("jal_target", imem_addr, 32'h0000_3040);
        mem_lat = 0;
        idle(1'b1);
        checkOutput("jal_if_pc", if_pc, 32'h0000_3040);

        // jr to a misaligned register value.
        applyStimulus(1'b1, 3'b011, 1'b0, 32'h0000_3040, 26'd0, 32'h0000_3022, 1'b1);
`ifdef IFETCH_ALIGN_CHECK_EN
        checkOutput("jr_adel", {31'b0, adel_err}, 32'd1);
        idle(1'b1);
        checkOutput("fault_no_req", {31'b0, imem_req}, 32'd0);
`else
        checkOutput("jr_forced_align", imem_addr, 32'h0000_3020);
`endif

        // Reset pulled while a request is outstanding; a stray ack during BOOT is ignored.
        doReset();
        mem_lat = 3;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("pre_rst_req", {31'b0, imem_req}, 32'd1);
        doReset();
        stale_ack = 1'b1;
        idle(1'b1);
        checkOutput("stale_ack_ignored", {31'b0, imem_req}, 32'd0);
        idle(1'b1);
        checkOutput("refetch_addr", imem_addr, 32'h0000_3000);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 249) doReset();
            mem_lat = $urandom_range(0, 3);
`ifdef IFETCH_ALIGN_CHECK_EN
            rreg = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
`else
            rreg = $urandom;
`endif
            applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          $urandom & 32'hFFFF_FFFC, 26'($urandom), rreg, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
